mux_sel_sched: RTL and testbench
================================

Name: mux_sel_sched

Overview:
- Select-line controller that sits directly upstream of the 2:1 mux array. Drives its select S and registers its output Q.
- Arbitrates between two valid/ready source channels using a sticky grant with a burst limit.
- Holds S stable for one settle cycle, then captures Q into a valid/ready output register. It also pops the winning source in that cycle.
- Used wherever two producers share one mux-selected datapath.

Parameters:
- WIDTH, 8, data width of the mux array output Q and of out_data.
- HOLD_MAX, 4, maximum consecutive captures from one channel while the other is waiting. Must be ≥1; 1 gives strict alternation.

Ports:
- clk  input  1  system clock, rising edge.
- rst  input  1  reset, asynchronous, active-high.
- D0_valid  input  1  channel 0 has data on mux input D0.
- D0_ready  output  1  channel 0 beat consumed this cycle.
- D1_valid  input  1  channel 1 has data on mux input D1.
- D1_ready  output  1  channel 1 beat consumed this cycle.
- S  output  1  registered select to the mux array (0→D0, 1→D1).
- Q  input  WIDTH  mux array output.
- out_valid  output  1  out_data holds a captured beat.
- out_ready  input  1  downstream accepts the beat.
- out_data  output  WIDTH  captured Q.
- out_src  output  1  channel that produced out_data.

Behaviour:
- One clock domain, clk. Reset rst is asynchronous and active-high.
- Reset values:
  - state=IDLE, S=0, last=0, burst_cnt=0.
  - out_valid=0, out_data=0, out_src=0.
  - D0_ready=D1_ready=0.
- Reset mid-operation: all registers return to these values immediately on rst assertion. Readys drop in the same cycle. Any pending beat is dropped.
- Output slot: slot_free = !out_valid || out_ready.
- out_valid clears on the edge where out_valid && out_ready, unless a new capture occurs on that edge.
- States: IDLE, SETTLE.
- IDLE, neither valid: stay in IDLE; S holds its value.
- IDLE, exactly one valid: winner w = that channel.
- IDLE, both valid: w = last if burst_cnt < HOLD_MAX, else w = !last.
- IDLE transition: S <= w; next state SETTLE.
- SETTLE, slot_free=1:
  - Assert Dw_ready for this cycle only.
  - out_data <= Q, out_src <= S, out_valid <= 1.
  - If w == last, burst_cnt <= min(burst_cnt+1, HOLD_MAX); else burst_cnt <= 1.
  - last <= w; next state IDLE.
- SETTLE, slot_free=0: stay in SETTLE. Both readys stay low; S and out_data are unchanged.
- Ready generation: Dn_ready = (state==SETTLE) && (S==n) && slot_free. Combinational, never both high.
- Source rule: each source holds valid and data stable from assertion until its ready. The block does not re-check valid in SETTLE; a protocol violation still captures Q.
- Latency: valid sampled in IDLE at cycle n:
  - S changes at cycle n+1; ready is high in cycle n+1 (if slot free).
  - out_valid is high from cycle n+2.
- Throughput: at most one beat per 2 cycles.
- The burst counter saturates at HOLD_MAX. It never wraps.

Test Plan:
- Reset: WIDTH=8, hold rst=1 with both valids high → S=0, out_valid=0, out_data=0x00, out_src=0, D0_ready=D1_ready=0. Release rst → first grant is to channel 0.
- Single beat: D1_valid=1 at cycle 0, mux model Q = S?D1:D0, D1=0xA5, out_ready=1.
  - Cycle 1: S=1, D1_ready=1 for exactly one cycle.
  - Cycle 2: out_valid=1, out_data=0xA5, out_src=1.
- Burst limit: HOLD_MAX=2, both valids held high, out_ready=1 → out_src sequence 0,0,1,1,0,0, one beat every 2 cycles. Repeat with HOLD_MAX=1 → 0,1,0,1.
- Backpressure: out_valid=1, out_ready=0, D0_valid=1 → block stays in SETTLE, D0_ready=0, out_data unchanged. Pulse out_ready=1 for one cycle → D0_ready=1 that same cycle; out_data updates to D0 on the next edge; out_valid stays 1.
- Reset in SETTLE: assert rst while D1_ready=1 → D1_ready=0 in the same cycle, S=0, out_valid=0. After release with both valid → channel 0 wins (burst_cnt=0).

Source files
------------

// File: rtl/mux_sel_sched_if.sv
// Handshake and datapath bundle between mux_sel_sched and its environment.
// master is the scheduler side, slave is the sources/mux/sink side.
interface mux_sel_sched_if #(
    parameter int WIDTH = 8
);
    logic             D0_valid;
    logic             D0_ready;
    logic             D1_valid;
    logic             D1_ready;
    logic             S;
    logic [WIDTH-1:0] Q;
    logic             out_valid;
    logic             out_ready;
    logic [WIDTH-1:0] out_data;
    logic             out_src;

    modport master (
        input  D0_valid, D1_valid, Q, out_ready,
        output D0_ready, D1_ready, S,
        output out_valid, out_data, out_src
    );

    modport slave (
        output D0_valid, D1_valid, Q, out_ready,
        input  D0_ready, D1_ready, S,
        input  out_valid, out_data, out_src
    );
endinterface

// File: rtl/mux_sel_sched.sv
// Select-line scheduler for a 2:1 mux array: sticky grant with burst
// limit, one settle cycle on S, then capture of Q into an output slot.
module mux_sel_sched #(
    parameter int WIDTH    = 8,
    parameter int HOLD_MAX = 4
) (
    input  logic               clk,
    input  logic               rst,
    mux_sel_sched_if.master    bus
);
    localparam int BW = $clog2(HOLD_MAX + 1);
    localparam logic [BW-1:0] HMAX = BW'(HOLD_MAX);

    typedef enum logic {IDLE, SETTLE} state_t;

    state_t           state, state_n;
    logic             s_q, s_n;
    logic             last;
    logic [BW-1:0]    burst_cnt;
    logic             ov_q;
    logic [WIDTH-1:0] od_q;
    logic             os_q;
    logic             w;
    logic             slot_free;
    logic             cap;

    assign slot_free = !ov_q || bus.out_ready;
    assign cap       = (state == SETTLE) && slot_free;

    // Sole requester wins outright; contention honours the burst limit.
    always_comb begin
        w = last;
        if (bus.D0_valid && !bus.D1_valid)
            w = 1'b0;
        else if (bus.D1_valid && !bus.D0_valid)
            w = 1'b1;
        else if (burst_cnt >= HMAX)
            w = !last;
    end

    always_comb begin
        state_n = state;
        s_n     = s_q;
        unique case (state)
            IDLE: begin
                if (bus.D0_valid || bus.D1_valid) begin
                    s_n     = w;
                    state_n = SETTLE;
                end
            end
            SETTLE: begin
                if (slot_free)
                    state_n = IDLE;
            end
            default: state_n = IDLE;
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state <= IDLE;
            s_q   <= 1'b0;
        end else begin
            state <= state_n;
            s_q   <= s_n;
        end
    end

    // S is the granted channel while in SETTLE.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            last      <= 1'b0;
            burst_cnt <= '0;
        end else if (cap) begin
            last <= s_q;
            if (s_q == last)
                burst_cnt <= (burst_cnt >= HMAX) ? HMAX : burst_cnt + 1'b1;
            else
                burst_cnt <= BW'(1);
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            ov_q <= 1'b0;
            od_q <= '0;
            os_q <= 1'b0;
        end else if (cap) begin
            ov_q <= 1'b1;
            od_q <= bus.Q;
            os_q <= s_q;
        end else if (bus.out_ready) begin
            ov_q <= 1'b0;
        end
    end

    assign bus.S         = s_q;
    assign bus.D0_ready  = cap && !s_q;
    assign bus.D1_ready  = cap && s_q;
    assign bus.out_valid = ov_q;
    assign bus.out_data  = od_q;
    assign bus.out_src   = os_q;
endmodule

// File: tb/tb_mux_sel_sched.sv
// Directed bench for mux_sel_sched: vector table on a HOLD_MAX=4 instance,
// plus burst-limit runs on HOLD_MAX=2 and HOLD_MAX=1 instances.
module tb_mux_sel_sched;
    logic clk = 1'b0;
    logic rst_a;
    logic rst_bc;
    logic [7:0] a_d0, a_d1;

    int n_chk  = 0;
    int n_fail = 0;

    always #5 clk = ~clk;

    mux_sel_sched_if #(.WIDTH(8)) ia ();
    mux_sel_sched_if #(.WIDTH(8)) ib ();
    mux_sel_sched_if #(.WIDTH(8)) ic ();

    assign ia.Q = ia.S ? a_d1 : a_d0;
    assign ib.Q = ib.S ? 8'hB1 : 8'hB0;
    assign ic.Q = ic.S ? 8'hC1 : 8'hC0;

    mux_sel_sched #(.WIDTH(8), .HOLD_MAX(4)) dut_a (
        .clk(clk), .rst(rst_a), .bus(ia.master));
    mux_sel_sched #(.WIDTH(8), .HOLD_MAX(2)) dut_b (
        .clk(clk), .rst(rst_bc), .bus(ib.master));
    mux_sel_sched #(.WIDTH(8), .HOLD_MAX(1)) dut_c (
        .clk(clk), .rst(rst_bc), .bus(ic.master));

    task automatic chk(input string name, input logic [31:0] act,
                       input logic [31:0] exp);
        n_chk++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    typedef struct {
        logic       rst, d0v, d1v, ordy;
        logic [7:0] d0, d1;
        logic       s, r0, r1, ov;
        logic [7:0] od;
        logic       os;
    } vec_t;

    vec_t tbl [13];

    // Burst-run bookkeeping.
    logic gb [$];
    logic gc [$];
    int   cb [$];
    int   cc [$];

    initial begin
        logic pb, pc, hb, hc, seen, exp_b, exp_c;
        int   k;

        // rst d0v d1v ordy d0 d1 | S r0 r1 ov od os
        tbl[0]  = '{1,1,1,1,8'h00,8'h00, 0,0,0,0,8'h00,0};
        tbl[1]  = '{0,0,1,1,8'h00,8'hA5, 0,0,0,0,8'h00,0};
        tbl[2]  = '{0,0,1,1,8'h00,8'hA5, 1,0,1,0,8'h00,0};
        tbl[3]  = '{0,0,0,1,8'h00,8'hA5, 1,0,0,1,8'hA5,1};
        tbl[4]  = '{0,0,0,1,8'h00,8'hA5, 1,0,0,0,8'hA5,1};
        tbl[5]  = '{1,1,1,1,8'h3C,8'hA5, 0,0,0,0,8'h00,0};
        tbl[6]  = '{0,1,1,1,8'h3C,8'hA5, 0,0,0,0,8'h00,0};
        tbl[7]  = '{0,1,1,1,8'h3C,8'hA5, 0,1,0,0,8'h00,0};
        tbl[8]  = '{0,1,0,0,8'h5A,8'hA5, 0,0,0,1,8'h3C,0};
        tbl[9]  = '{0,1,0,0,8'h5A,8'hA5, 0,0,0,1,8'h3C,0};
        tbl[10] = '{0,1,0,0,8'h5A,8'hA5, 0,0,0,1,8'h3C,0};
        tbl[11] = '{0,1,0,1,8'h5A,8'hA5, 0,1,0,1,8'h3C,0};
        tbl[12] = '{0,0,0,0,8'h5A,8'hA5, 0,0,0,1,8'h5A,0};

        rst_a  = 1'b1;
        rst_bc = 1'b1;
        a_d0 = 8'h00;
        a_d1 = 8'h00;
        ia.D0_valid = 1'b1; ia.D1_valid = 1'b1; ia.out_ready = 1'b1;
        ib.D0_valid = 1'b1; ib.D1_valid = 1'b1; ib.out_ready = 1'b1;
        ic.D0_valid = 1'b1; ic.D1_valid = 1'b1; ic.out_ready = 1'b1;

        for (int i = 0; i < 13; i++) begin
            @(negedge clk);
            rst_a       = tbl[i].rst;
            ia.D0_valid = tbl[i].d0v;
            ia.D1_valid = tbl[i].d1v;
            ia.out_ready = tbl[i].ordy;
            a_d0 = tbl[i].d0;
            a_d1 = tbl[i].d1;
            #1;
            chk($sformatf("v%0d S", i), 32'(ia.S), 32'(tbl[i].s));
            chk($sformatf("v%0d D0_ready", i), 32'(ia.D0_ready), 32'(tbl[i].r0));
            chk($sformatf("v%0d D1_ready", i), 32'(ia.D1_ready), 32'(tbl[i].r1));
            chk($sformatf("v%0d out_valid", i), 32'(ia.out_valid), 32'(tbl[i].ov));
            chk($sformatf("v%0d out_data", i), 32'(ia.out_data), 32'(tbl[i].od));
            chk($sformatf("v%0d out_src", i), 32'(ia.out_src), 32'(tbl[i].os));
        end

        // Reset while D1_ready is high.
        @(negedge clk);
        ia.D0_valid = 1'b0; ia.D1_valid = 1'b1;
        ia.out_ready = 1'b1; a_d1 = 8'h77;
        @(negedge clk); #1;
        chk("settle S", 32'(ia.S), 32'd1);
        chk("settle D1_ready", 32'(ia.D1_ready), 32'd1);
        #1 rst_a = 1'b1;
        #1;
        chk("rst D1_ready", 32'(ia.D1_ready), 32'd0);
        chk("rst S", 32'(ia.S), 32'd0);
        chk("rst out_valid", 32'(ia.out_valid), 32'd0);
        @(negedge clk);
        rst_a = 1'b0;
        ia.D0_valid = 1'b1; ia.D1_valid = 1'b1;
        seen = 1'b0;
        for (int t = 0; t < 4 && !seen; t++) begin
            @(negedge clk); #1;
            if (ia.D0_ready || ia.D1_ready) begin
                seen = 1'b1;
                chk("post-rst D0 wins", 32'(ia.D0_ready), 32'd1);
                chk("post-rst D1 idle", 32'(ia.D1_ready), 32'd0);
            end
        end
        chk("post-rst grant seen", 32'(seen), 32'd1);

        // Burst limit: both channels always valid, sink always ready.
        @(negedge clk);
        rst_bc = 1'b0;
        pb = 1'b0; pc = 1'b0; hb = 1'b0; hc = 1'b0;
        for (int t = 0; t < 14; t++) begin
            @(negedge clk); #1;
            if (pb) begin
                chk("B out_valid", 32'(ib.out_valid), 32'd1);
                chk("B out_src", 32'(ib.out_src), 32'(hb));
                chk("B out_data", 32'(ib.out_data),
                    32'(hb ? 8'hB1 : 8'hB0));
            end
            if (pc) begin
                chk("C out_src", 32'(ic.out_src), 32'(hc));
                chk("C out_data", 32'(ic.out_data),
                    32'(hc ? 8'hC1 : 8'hC0));
            end
            chk("B ready exclusive", 32'(ib.D0_ready && ib.D1_ready), 32'd0);
            chk("C ready exclusive", 32'(ic.D0_ready && ic.D1_ready), 32'd0);
            pb = ib.D0_ready || ib.D1_ready;
            pc = ic.D0_ready || ic.D1_ready;
            hb = ib.D1_ready;
            hc = ic.D1_ready;
            if (pb) begin gb.push_back(hb); cb.push_back(t); end
            if (pc) begin gc.push_back(hc); cc.push_back(t); end
        end

        chk("B grant count", 32'(gb.size() >= 6), 32'd1);
        chk("C grant count", 32'(gc.size() >= 6), 32'd1);
        k = (gb.size() < 6) ? gb.size() : 6;
        for (int i = 0; i < k; i++) begin
            exp_b = (i == 2 || i == 3);
            chk($sformatf("B seq[%0d]", i), 32'(gb[i]), 32'(exp_b));
            if (i > 0)
                chk($sformatf("B gap[%0d]", i), 32'(cb[i] - cb[i-1]), 32'd2);
        end
        k = (gc.size() < 6) ? gc.size() : 6;
        for (int i = 0; i < k; i++) begin
            exp_c = (i % 2 == 1);
            chk($sformatf("C seq[%0d]", i), 32'(gc[i]), 32'(exp_c));
            if (i > 0)
                chk($sformatf("C gap[%0d]", i), 32'(cc[i] - cc[i-1]), 32'd2);
        end

        $display("End of test - %0d assertions evaluated, %0d failures",
                 n_chk, n_fail);
        $finish;
    end
endmodule
